// File: rtl/matrix_scan_driver.sv
// ---------------------------------------------------------------------------
// matrix_scan_driver
//
// Scans an 8x8 bi-colour (red/green) LED matrix one row at a time. Each row
// is preceded by a blanking gap in which every LED is off, so row switching
// never lights a pixel in the wrong row. The frame maps are captured into
// shadow registers once per frame, at the start of row 0, so the picture
// never tears.
//
// Parameters:
//   DWELL_CYCLES  clock cycles each row is driven        (1..65535)
//   BLANK_CYCLES  clock cycles of blanking before a row  (1..65535)
//
// Ports:
//   clock         system clock, rising-edge active
//   reset         asynchronous, active-low reset
//   red_frame     red pixel map, bit r*8+c = row r, column c, 1 = lit
//   green_frame   green pixel map, same mapping as red_frame
//   display_en    1 = drive LEDs, 0 = force all LEDs off (scan keeps running)
//   red_driver    red column drive for the active row, 1 = on
//   green_driver  green column drive for the active row, 1 = on
//   row_sink      row select, active-low, 1 = row off
//   frame_done    one-cycle pulse at the end of each full 8-row scan
// ---------------------------------------------------------------------------
module matrix_scan_driver #(
    parameter int unsigned DWELL_CYCLES = 1024,
    parameter int unsigned BLANK_CYCLES = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [63:0] red_frame,
    input  logic [63:0] green_frame,
    input  logic        display_en,
    output logic [7:0]  red_driver,
    output logic [7:0]  green_driver,
    output logic [7:0]  row_sink,
    output logic        frame_done
);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    localparam logic [15:0] BLANK_LAST = 16'(BLANK_CYCLES - 1);
    localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [2:0]  row;
    logic [2:0]  row_next;
    logic [15:0] count;
    logic [15:0] count_next;
    logic [63:0] red_shadow;
    logic [63:0] red_shadow_next;
    logic [63:0] green_shadow;
    logic [63:0] green_shadow_next;

    logic [7:0]  red_driver_next;
    logic [7:0]  green_driver_next;
    logic [7:0]  row_sink_next;
    logic        frame_done_next;

    // Next-state and next-output logic. Outputs are derived from the current
    // (pre-edge) state and registered, so pins lag the state by one cycle.
    always_comb begin
        state_next        = state;
        row_next          = row;
        count_next        = count + 16'd1;
        red_shadow_next   = red_shadow;
        green_shadow_next = green_shadow;
        red_driver_next   = 8'h00;
        green_driver_next = 8'h00;
        row_sink_next     = 8'hFF;
        frame_done_next   = 1'b0;

        // The shadows only change at the very start of a frame, so a frame
        // is always displayed from one consistent snapshot.
        if (state == BLANK && row == 3'd0 && count == 16'd0) begin
            red_shadow_next   = red_frame;
            green_shadow_next = green_frame;
        end

        case (state)
            BLANK: begin
                if (count == BLANK_LAST) begin
                    state_next = DRIVE;
                    count_next = 16'd0;
                end
            end
            DRIVE: begin
                if (display_en) begin
                    red_driver_next   = red_shadow[{row, 3'b000} +: 8];
                    green_driver_next = green_shadow[{row, 3'b000} +: 8];
                    row_sink_next     = ~(8'd1 << row);
                end
                if (count == DWELL_LAST) begin
                    state_next      = BLANK;
                    count_next      = 16'd0;
                    row_next        = row + 3'd1;
                    frame_done_next = (row == 3'd7);
                end
            end
            default: begin
                state_next = BLANK;
                count_next = 16'd0;
            end
        endcase
    end

    // State, shadow and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= BLANK;
            row          <= 3'd0;
            count        <= 16'd0;
            red_shadow   <= 64'd0;
            green_shadow <= 64'd0;
            red_driver   <= 8'h00;
            green_driver <= 8'h00;
            row_sink     <= 8'hFF;
            frame_done   <= 1'b0;
        end else begin
            state        <= state_next;
            row          <= row_next;
            count        <= count_next;
            red_shadow   <= red_shadow_next;
            green_shadow <= green_shadow_next;
            red_driver   <= red_driver_next;
            green_driver <= green_driver_next;
            row_sink     <= row_sink_next;
            frame_done   <= frame_done_next;
        end
    end

endmodule

// File: doc/matrix_scan_driver.md
MATRIX_SCAN_DRIVER -- requirements
Module: matrix_scan_driver

Interface
REQ-001 The block SHALL have parameter DWELL_CYCLES, default 1024: clock cycles each row is driven; legal range 1..65535.
REQ-002 The block SHALL have parameter BLANK_CYCLES, default 16: clock cycles all LEDs are off before each row; legal range 1..65535.
REQ-003 The block SHALL have port clock, input, 1 bit: system clock, rising-edge active.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port red_frame, input, 64 bits: red pixel map; bit r*8+c is row r, column c; 1 = lit.
REQ-006 The block SHALL have port green_frame, input, 64 bits: green pixel map, same bit mapping as red_frame.
REQ-007 The block SHALL have port display_en, input, 1 bit: 1 = drive LEDs, 0 = force all LEDs off.
REQ-008 The block SHALL have port red_driver, output, 8 bits: red column drive for the active row; 1 = on.
REQ-009 The block SHALL have port green_driver, output, 8 bits: green column drive for the active row; 1 = on.
REQ-010 The block SHALL have port row_sink, output, 8 bits: row select, active-low; 1 = row off.
REQ-011 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each full 8-row scan.

Function
REQ-012 The block SHALL keep this state:
- a two-state FSM, BLANK and DRIVE;
- a 3-bit row index;
- a 16-bit cycle counter;
- 64-bit red and green shadow frames.
REQ-013 In each state the cycle counter SHALL count from 0 to (state length - 1); state length is BLANK_CYCLES in BLANK and DWELL_CYCLES in DRIVE.
REQ-014 At BLANK with count BLANK_CYCLES-1, the FSM SHALL go to DRIVE with the counter cleared.
REQ-015 At DRIVE with count DWELL_CYCLES-1, the FSM SHALL go to BLANK with the counter cleared and the row incremented; row 7 SHALL wrap to 0.
REQ-016 On every edge where state=BLANK, row=0 and count=0, both shadow frames SHALL load from red_frame and green_frame.
REQ-017 Input changes at any other time SHALL NOT affect the outputs until the next shadow load, so no frame tearing occurs.
REQ-018 All outputs SHALL be registered and computed from the pre-edge state, giving exactly one cycle of latency from state to pins.
REQ-019 Output values computed from state DRIVE with row r and display_en=1 SHALL be:
- red_driver = red shadow bits [r*8+7 : r*8];
- green_driver = green shadow bits [r*8+7 : r*8];
- row_sink = all ones except bit r = 0.
REQ-020 Output values computed from state BLANK, or with display_en=0, SHALL be: red_driver=8'h00, green_driver=8'h00, row_sink=8'hFF.
REQ-021 The scan counters SHALL keep running while display_en=0.
REQ-022 A pixel set in both frames SHALL drive both colours at once, producing yellow; there is no colour priority.
REQ-023 frame_done SHALL be 1 for exactly the one cycle after the edge where state=DRIVE, row=7 and count=DWELL_CYCLES-1, and 0 otherwise.
REQ-024 The frame period SHALL be exactly 8*(BLANK_CYCLES+DWELL_CYCLES) cycles.
REQ-025 At no cycle SHALL more than one row_sink bit be 0.
REQ-026 When a row_sink bit changes, no driver bit SHALL be 1 in the same cycle; this follows from the BLANK gap.
REQ-027 With BLANK_CYCLES=1 or DWELL_CYCLES=1, each state SHALL last exactly one cycle and shall not be skipped.

Reset
REQ-028 While reset=0, outputs SHALL immediately and asynchronously be: red_driver=8'h00, green_driver=8'h00, row_sink=8'hFF, frame_done=0.
REQ-029 Reset SHALL set state=BLANK, row=0, count=0 and both shadow frames=0.
REQ-030 Reset asserted mid-row or mid-frame SHALL abandon the current scan; after release the scan SHALL restart at row 0 and reload the shadows on the first edge.

Verification
All scenarios use DWELL_CYCLES=4 and BLANK_CYCLES=2 (48-cycle frame); edges are counted from reset release.
REQ-031 Basic row-0 drive:
- stimulus: red_frame=64'h0F, green_frame=0, display_en=1;
- response: outputs off for edges 1-2; red_driver=8'h0F, row_sink=8'hFE after edges 3-6; off after edge 7.
REQ-032 Full-frame scan:
- stimulus: green_frame=64'hFF..FF;
- response: rows 0..7 sink in order, each for 4 cycles with green_driver=8'hFF;
- response: frame_done high only after edges 48, 96, ...
REQ-033 Tear-free update:
- stimulus: change red_frame mid-frame;
- response: the new value appears no earlier than row 0 of the next frame.
REQ-034 Yellow pixel:
- stimulus: red_frame and green_frame both bit 63 set;
- response: red_driver=8'h80, green_driver=8'h80, row_sink=8'h7F during the row-7 dwell.
REQ-035 Display disable:
- stimulus: display_en=0 during row 3;
- response: all outputs off on the next edge;
- response: on re-enable, driving resumes at the row consistent with uninterrupted counting.
REQ-036 Reset mid-row:
- stimulus: reset low during the row-5 dwell;
- response: outputs go off asynchronously; after release, row 0 is driven at edges 3-6.
